rv32i_stage_ctrl: RTL and testbench

Parametrised multi-cycle stage controller for the unpipelined RV32I core. It is the successor to the fixed five-stage sequencer.
- Sequences FETCH/DECODE/EXECUTE/MEMORYACCESS/WRITEBACK with ack-based instruction and data memory handshakes.
- Supports a generic stall, trap/flush abort and an optional fast path that skips MEMORYACCESS for non-memory instructions.
- Drives the ALU operand muxes and the stage enables.
- Counts retired instructions.

---
 rtl/rv32i_stage_ctrl.sv | 153 +++++++++++++++
 tb/tb_rv32i_stage_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_stage_ctrl.sv
// Stage controller for the unpipelined RV32I core: sequences FETCH..WRITEBACK with ack handshakes,
// stall/trap abort, optional MEMORYACCESS bypass, ALU operand muxing and a retired-instruction count.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH  11
`define OPCODE_RTYPE  0
`define OPCODE_ITYPE  1
`define OPCODE_LOAD   2
`define OPCODE_STORE  3
`define OPCODE_BRANCH 4
`define OPCODE_JAL    5
`define OPCODE_JALR   6
`define OPCODE_LUI    7
`define OPCODE_AUIPC  8
`define OPCODE_SYSTEM 9
`define OPCODE_FENCE  10
`endif

module rv32i_stage_ctrl #(
   parameter int XLEN      = 32,
   parameter int FAST_PATH = 1,
   parameter int RET_W     = 32
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [XLEN-1:0]          i_inst,
   input  logic                     i_imem_ack,
   input  logic                     i_dmem_ack,
   input  logic                     i_stall,
   input  logic                     i_trap,
   input  logic [XLEN-1:0]          i_pc,
   input  logic [XLEN-1:0]          i_rs1_data,
   input  logic [XLEN-1:0]          i_rs2_data,
   input  logic [XLEN-1:0]          i_imm,
   input  logic [`OPCODE_WIDTH-1:0] i_opcode,
   output logic [XLEN-1:0]          o_inst_q,
   output logic [2:0]               o_stage_q,
   output logic [XLEN-1:0]          o_op1,
   output logic [XLEN-1:0]          o_op2,
   output logic                     o_imem_req,
   output logic                     o_dmem_req,
   output logic                     o_alu_stage_en,
   output logic                     o_memoryaccess_stage_en,
   output logic                     o_writeback_stage_en,
   output logic                     o_trap_taken,
   output logic [RET_W-1:0]         o_retired
);

   localparam logic [2:0] FETCH        = 3'd0;
   localparam logic [2:0] DECODE       = 3'd1;
   localparam logic [2:0] EXECUTE      = 3'd2;
   localparam logic [2:0] MEMORYACCESS = 3'd3;
   localparam logic [2:0] WRITEBACK    = 3'd4;

   logic [2:0]       stage;
   logic [2:0]       stage_nxt;
   logic [XLEN-1:0]  inst_q;
   logic [RET_W-1:0] retired;

   logic is_load;
   logic is_store;
   logic is_mem;
   logic is_rtype;
   logic is_branch;
   logic is_jal;
   logic is_auipc;
   logic unused_opcode;

   assign is_load   = i_opcode[`OPCODE_LOAD];
   assign is_store  = i_opcode[`OPCODE_STORE];
   assign is_mem    = is_load | is_store;
   assign is_rtype  = i_opcode[`OPCODE_RTYPE];
   assign is_branch = i_opcode[`OPCODE_BRANCH];
   assign is_jal    = i_opcode[`OPCODE_JAL];
   assign is_auipc  = i_opcode[`OPCODE_AUIPC];
   assign unused_opcode = ^{i_opcode[`OPCODE_ITYPE], i_opcode[`OPCODE_JALR], i_opcode[`OPCODE_LUI],
                            i_opcode[`OPCODE_SYSTEM], i_opcode[`OPCODE_FENCE]};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stage <= FETCH;
      end else begin
         stage <= stage_nxt;
      end
   end

   // Trap outranks stall in every stage except FETCH, where both are ignored.
   always_comb begin
      stage_nxt = stage;
      case (stage)
         FETCH: begin
            if (i_imem_ack) stage_nxt = DECODE;
         end
         DECODE: begin
            if (i_trap)        stage_nxt = FETCH;
            else if (!i_stall) stage_nxt = EXECUTE;
         end
         EXECUTE: begin
            if (i_trap)                                stage_nxt = FETCH;
            else if (!i_stall && (is_mem || FAST_PATH == 0)) stage_nxt = MEMORYACCESS;
            else if (!i_stall)                         stage_nxt = WRITEBACK;
         end
         MEMORYACCESS: begin
            if (i_trap)                     stage_nxt = FETCH;
            else if (!is_mem || i_dmem_ack) stage_nxt = WRITEBACK;
         end
         WRITEBACK: begin
            if (i_trap || !i_stall) stage_nxt = FETCH;
         end
         default: stage_nxt = FETCH;
      endcase
   end

   always_comb begin
      o_imem_req              = 1'b0;
      o_dmem_req              = 1'b0;
      o_alu_stage_en          = 1'b0;
      o_memoryaccess_stage_en = 1'b0;
      o_writeback_stage_en    = 1'b0;
      o_op1                   = '0;
      o_op2                   = '0;
      o_trap_taken            = i_trap && (stage != FETCH);
      case (stage)
         FETCH: o_imem_req = 1'b1;
         EXECUTE: begin
            o_alu_stage_en = !i_stall && !i_trap;
            o_op1          = (is_jal || is_auipc) ? i_pc : i_rs1_data;
            o_op2          = (is_rtype || is_branch) ? i_rs2_data : i_imm;
         end
         MEMORYACCESS: begin
            o_memoryaccess_stage_en = 1'b1;
            o_dmem_req              = is_mem;
         end
         WRITEBACK: o_writeback_stage_en = !i_stall && !i_trap;
         default: ;
      endcase
   end

   // The instruction register survives a trap so the handler can inspect the faulting word.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         inst_q  <= '0;
         retired <= '0;
      end else begin
         if (stage == FETCH && i_imem_ack) inst_q <= i_inst;
         if (o_writeback_stage_en)         retired <= retired + RET_W'(1);
      end
   end

   assign o_stage_q = stage;
   assign o_inst_q  = inst_q;
   assign o_retired = retired;

endmodule

// File: tb/tb_rv32i_stage_ctrl.sv
// Bench for rv32i_stage_ctrl: one FAST_PATH=0 instance and one FAST_PATH=1/RET_W=4 instance share stimulus;
// a route-position model is compared every cycle, plus directed literal expectations.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH  11
`define OPCODE_RTYPE  0
`define OPCODE_ITYPE  1
`define OPCODE_LOAD   2
`define OPCODE_STORE  3
`define OPCODE_BRANCH 4
`define OPCODE_JAL    5
`define OPCODE_JALR   6
`define OPCODE_LUI    7
`define OPCODE_AUIPC  8
`define OPCODE_SYSTEM 9
`define OPCODE_FENCE  10
`endif

module tb_rv32i_stage_ctrl;
   logic clk;
   logic rst_n;
   logic [31:0] inst, pc, rs1, rs2, imm;
   logic imem_ack, dmem_ack, stall, trap;
   logic [`OPCODE_WIDTH-1:0] opcode;

   logic [31:0] inst0, op1_0, op2_0, ret0;
   logic [2:0]  stage0;
   logic imem0, dmem0, alu0, mem0, wb0, tt0;
   logic [31:0] inst1, op1_1, op2_1;
   logic [3:0]  ret1;
   logic [2:0]  stage1;
   logic imem1, dmem1, alu1, mem1, wb1, tt1;

   int checks = 0;
   int errors = 0;
   int m_pos [2];
   logic [31:0] m_inst [2];
   logic [31:0] m_ret [2];
   int seq_a [10];
   int seq_b [10];
   int alu_cnt1, wb_cnt1, wb_cnt0;

   rv32i_stage_ctrl #(.XLEN(32), .FAST_PATH(0), .RET_W(32)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_inst(inst), .i_imem_ack(imem_ack), .i_dmem_ack(dmem_ack),
      .i_stall(stall), .i_trap(trap), .i_pc(pc), .i_rs1_data(rs1), .i_rs2_data(rs2), .i_imm(imm),
      .i_opcode(opcode), .o_inst_q(inst0), .o_stage_q(stage0), .o_op1(op1_0), .o_op2(op2_0),
      .o_imem_req(imem0), .o_dmem_req(dmem0), .o_alu_stage_en(alu0), .o_memoryaccess_stage_en(mem0),
      .o_writeback_stage_en(wb0), .o_trap_taken(tt0), .o_retired(ret0));

   rv32i_stage_ctrl #(.XLEN(32), .FAST_PATH(1), .RET_W(4)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_inst(inst), .i_imem_ack(imem_ack), .i_dmem_ack(dmem_ack),
      .i_stall(stall), .i_trap(trap), .i_pc(pc), .i_rs1_data(rs1), .i_rs2_data(rs2), .i_imm(imm),
      .i_opcode(opcode), .o_inst_q(inst1), .o_stage_q(stage1), .o_op1(op1_1), .o_op2(op2_1),
      .o_imem_req(imem1), .o_dmem_req(dmem1), .o_alu_stage_en(alu1), .o_memoryaccess_stage_en(mem1),
      .o_writeback_stage_en(wb1), .o_trap_taken(tt1), .o_retired(ret1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic is_mem_op();
      return opcode[`OPCODE_LOAD] | opcode[`OPCODE_STORE];
   endfunction

   // Instance 0 always walks all five stages; instance 1 skips MEMORYACCESS for non-memory ops.
   function automatic int route_len(input int i);
      return (is_mem_op() || i == 0) ? 5 : 4;
   endfunction

   function automatic int route_stage(input int i, input int pos);
      return (route_len(i) == 4 && pos == 3) ? 4 : pos;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_pos[i]  <= 0;
            m_inst[i] <= '0;
            m_ret[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (m_pos[i] == 0) begin
               if (imem_ack) begin
                  m_pos[i]  <= 1;
                  m_inst[i] <= inst;
               end
            end else if (trap) begin
               m_pos[i] <= 0;
            end else if (route_stage(i, m_pos[i]) == 3) begin
               if (!is_mem_op() || dmem_ack) m_pos[i] <= m_pos[i] + 1;
            end else if (!stall) begin
               if (m_pos[i] == route_len(i) - 1) begin
                  m_pos[i] <= 0;
                  m_ret[i] <= (m_ret[i] + 32'd1) & ((i == 1) ? 32'h0000_000F : 32'hFFFF_FFFF);
               end else begin
                  m_pos[i] <= m_pos[i] + 1;
               end
            end
         end
      end
   end

   task automatic compare_inst(input int i, input logic [31:0] st_a, input logic [31:0] inst_a,
                               input logic [31:0] ret_a, input logic [31:0] op1_a, input logic [31:0] op2_a,
                               input logic imem_a, input logic dmem_a, input logic alu_a, input logic mem_a,
                               input logic wb_a, input logic tt_a);
      int st;
      logic [31:0] e_op1, e_op2;
      st    = route_stage(i, m_pos[i]);
      e_op1 = '0;
      e_op2 = '0;
      if (st == 2) begin
         e_op1 = (opcode[`OPCODE_JAL] || opcode[`OPCODE_AUIPC]) ? pc : rs1;
         e_op2 = (opcode[`OPCODE_RTYPE] || opcode[`OPCODE_BRANCH]) ? rs2 : imm;
      end
      check($sformatf("d%0d.stage", i), st_a, 32'(st));
      check($sformatf("d%0d.inst_q", i), inst_a, m_inst[i]);
      check($sformatf("d%0d.retired", i), ret_a, m_ret[i]);
      check($sformatf("d%0d.op1", i), op1_a, e_op1);
      check($sformatf("d%0d.op2", i), op2_a, e_op2);
      check($sformatf("d%0d.imem_req", i), 32'(imem_a), 32'(st == 0));
      check($sformatf("d%0d.dmem_req", i), 32'(dmem_a), 32'(st == 3 && is_mem_op()));
      check($sformatf("d%0d.alu_en", i), 32'(alu_a), 32'(st == 2 && !stall && !trap));
      check($sformatf("d%0d.mem_en", i), 32'(mem_a), 32'(st == 3));
      check($sformatf("d%0d.wb_en", i), 32'(wb_a), 32'(st == 4 && !stall && !trap));
      check($sformatf("d%0d.trap_taken", i), 32'(tt_a), 32'(trap && st != 0));
   endtask

   always @(negedge clk) begin
      compare_inst(0, 32'(stage0), inst0, ret0, op1_0, op2_0, imem0, dmem0, alu0, mem0, wb0, tt0);
      compare_inst(1, 32'(stage1), inst1, 32'(ret1), op1_1, op2_1, imem1, dmem1, alu1, mem1, wb1, tt1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int idx);
      opcode      = '0;
      opcode[idx] = 1'b1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      stall    = 1'b0;
      trap     = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // One instruction: imem_ack pulses on step 0, stall/dmem_ack/trap follow per-step bit masks.
   // dut1 is pinned to seq_a, dut0 to seq_b; dut1 operands are pinned on steps op_lo..op_hi.
   task automatic run_instr(input int n, input int stall_m, input int dack_m, input int trap_m,
                            input int op_lo, input int op_hi, input logic [31:0] e1, input logic [31:0] e2);
      alu_cnt1 = 0;
      wb_cnt1  = 0;
      wb_cnt0  = 0;
      imem_ack = 1'b1;
      for (int k = 0; k < n; k++) begin
         stall    = stall_m[k];
         dmem_ack = dack_m[k];
         trap     = trap_m[k];
         #1;
         check("d1.seq_stage", 32'(stage1), seq_a[k]);
         check("d0.seq_stage", 32'(stage0), seq_b[k]);
         if (k >= op_lo && k <= op_hi) begin
            check("d1.exec_op1", op1_1, e1);
            check("d1.exec_op2", op2_1, e2);
         end
         alu_cnt1 += int'(alu1);
         wb_cnt1  += int'(wb1);
         wb_cnt0  += int'(wb0);
         tick();
         imem_ack = 1'b0;
      end
      stall    = 1'b0;
      dmem_ack = 1'b0;
      trap     = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      inst = '0; pc = '0; rs1 = '0; rs2 = '0; imm = '0;
      imem_ack = 1'b0; dmem_ack = 1'b0; stall = 1'b0; trap = 1'b0;
      opcode = '0;

      // R-type ADD: dut1 skips MEMORYACCESS, dut0 spends one cycle there with no data request
      do_reset();
      check("reset.stage", 32'(stage1), 32'd0);
      check("reset.imem_req", 32'(imem1), 32'd1);
      set_op(`OPCODE_RTYPE);
      inst = 32'h0073_02B3; rs1 = 32'd5; rs2 = 32'd7; imm = 32'h0000_0044; pc = 32'h40;
      seq_a = '{0, 1, 2, 4, 0, 0, 0, 0, 0, 0};
      seq_b = '{0, 1, 2, 3, 4, 0, 0, 0, 0, 0};
      run_instr(6, 0, 0, 0, 2, 2, 32'd5, 32'd7);
      check("add.alu_pulses", 32'(alu_cnt1), 32'd1);
      check("add.wb_pulses_d1", 32'(wb_cnt1), 32'd1);
      check("add.wb_pulses_d0", 32'(wb_cnt0), 32'd1);
      check("add.retired_d1", 32'(ret1), 32'd1);
      check("add.retired_d0", ret0, 32'd1);
      check("add.inst_q", inst1, 32'h0073_02B3);

      // Load with dmem_ack on the 4th MEMORYACCESS cycle; a stall inside MEMORYACCESS is ignored
      do_reset();
      set_op(`OPCODE_LOAD);
      inst = 32'h0041_2283; imm = 32'd4;
      seq_a = '{0, 1, 2, 3, 3, 3, 3, 4, 0, 0};
      seq_b = '{0, 1, 2, 3, 3, 3, 3, 4, 0, 0};
      run_instr(9, 32'h30, 32'h40, 0, 2, 2, rs1, 32'd4);
      check("load.wb_pulses", 32'(wb_cnt1), 32'd1);
      check("load.retired", 32'(ret1), 32'd1);

      // AUIPC stalled two cycles in EXECUTE: operands held, one ALU pulse on release
      set_op(`OPCODE_AUIPC);
      inst = 32'h0000_1297; pc = 32'h100; imm = 32'h1000; rs1 = 32'h55;
      seq_a = '{0, 1, 2, 2, 2, 4, 0, 0, 0, 0};
      seq_b = '{0, 1, 2, 2, 2, 3, 4, 0, 0, 0};
      run_instr(8, 32'h0C, 0, 0, 2, 4, 32'h100, 32'h1000);
      check("auipc.alu_pulses", 32'(alu_cnt1), 32'd1);
      check("auipc.retired", 32'(ret1), 32'd2);

      // Store: trap in FETCH ignored, trap with coincident dmem_ack in MEMORYACCESS aborts
      set_op(`OPCODE_STORE);
      inst = 32'h00A1_2023;
      seq_a = '{0, 1, 2, 3, 0, 0, 0, 0, 0, 0};
      seq_b = '{0, 1, 2, 3, 0, 0, 0, 0, 0, 0};
      run_instr(6, 0, 32'h08, 32'h09, 9, 9, 0, 0);
      check("trap.wb_pulses", 32'(wb_cnt1), 32'd0);
      check("trap.retired", 32'(ret1), 32'd2);
      check("trap.inst_kept", inst1, 32'h00A1_2023);

      // Asynchronous reset in the middle of EXECUTE
      set_op(`OPCODE_RTYPE);
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      tick();
      check("midrst.pre_stage", 32'(stage1), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst.stage", 32'(stage1), 32'd0);
      check("midrst.inst_q", inst1, 32'd0);
      check("midrst.retired", 32'(ret1), 32'd0);
      check("midrst.imem_req", 32'(imem1), 32'd1);
      check("midrst.retired_d0", ret0, 32'd0);
      tick();
      rst_n = 1'b1;

      // Back-to-back ADDs with zero-wait fetch: 4-bit counter wraps after 16 retirements
      do_reset();
      set_op(`OPCODE_RTYPE);
      imem_ack = 1'b1;
      repeat (60) tick();
      #1;
      check("wrap.retired_15", 32'(ret1), 32'd15);
      check("wrap.retired_d0", ret0, 32'd12);
      repeat (4) tick();
      #1;
      check("wrap.retired_0", 32'(ret1), 32'd0);
      check("wrap.stage", 32'(stage1), 32'd0);
      imem_ack = 1'b0;
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
